// File: rtl/aes_ctrl_pkg.sv
// Shared types and status-word layout for the AES stream controller.
// Holds the FSM encoding, pipeline tag, output buffer beat and status helpers.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } ctrl_state_e;

    localparam int unsigned BYTE_CNT_W   = 23;
    localparam int unsigned STS_W        = 32;
    localparam int unsigned STS_DONE_BIT = 31;
    localparam int unsigned STS_CNT_LSB  = 0;

    typedef struct packed {
        logic        valid;
        logic [15:0] keep;
        logic        last;
    } tag_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } obuf_beat_t;

    function automatic logic [4:0] keep_bytes(input logic [15:0] keep);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n = n + 5'(keep[i]);
        end
        return n;
    endfunction

    // Bits between the done flag and the byte count stay zero.
    function automatic logic [STS_W-1:0] make_status(input logic [BYTE_CNT_W-1:0] cnt);
        logic [STS_W-1:0] s;
        s = '0;
        s[STS_DONE_BIT] = 1'b1;
        s[STS_CNT_LSB +: BYTE_CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/aes_obuf_fifo.sv
// Output buffer for encrypted beats: FIFO with wrap-around pointers and an
// occupancy count; depth need not be a power of two.
module aes_obuf_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 145
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Streams mm2s beats through an external aes_256 core into s2mm, with
// key reload sequencing, credit-based input flow control and frame status.
module aes_stream_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned C_TDATA_WIDTH = 128,
    parameter int unsigned C_AES_LATENCY = 14,
    parameter int unsigned C_OBUF_DEPTH  = 16
) (
    input  logic                       m_axi_mm2s_aclk,
    input  logic                       axi_reset,
    input  logic                       ctrl_en,
    input  logic                       key_load,
    input  logic [255:0]               key_in,
    input  logic [C_TDATA_WIDTH-1:0]   m_axis_mm2s_tdata,
    input  logic [C_TDATA_WIDTH/8-1:0] m_axis_mm2s_tkeep,
    input  logic                       m_axis_mm2s_tvalid,
    input  logic                       m_axis_mm2s_tlast,
    output logic                       m_axis_mm2s_tready,
    output logic [C_TDATA_WIDTH-1:0]   aes_state,
    output logic [255:0]               aes_key,
    input  logic [C_TDATA_WIDTH-1:0]   aes_out,
    output logic [C_TDATA_WIDTH-1:0]   s_axis_s2mm_tdata,
    output logic [C_TDATA_WIDTH/8-1:0] s_axis_s2mm_tkeep,
    output logic                       s_axis_s2mm_tvalid,
    output logic                       s_axis_s2mm_tlast,
    input  logic                       s_axis_s2mm_tready,
    output logic [31:0]                s_axis_s2mm_sts_tdata,
    output logic [3:0]                 s_axis_s2mm_sts_tkeep,
    output logic                       s_axis_s2mm_sts_tvalid,
    output logic                       s_axis_s2mm_sts_tlast,
    input  logic                       s_axis_s2mm_sts_tready,
    output logic                       busy
);

    localparam int unsigned OCC_W = $clog2(C_OBUF_DEPTH + 1);

    wire clk = m_axi_mm2s_aclk;
    wire rst = axi_reset;

    ctrl_state_e           state;
    logic [255:0]          key_cap;
    tag_t                  tag_sr [C_AES_LATENCY];
    logic [31:0]           inflight;
    logic [OCC_W-1:0]      occ;
    logic                  obuf_empty;
    logic                  accept;
    logic                  obuf_rd;
    obuf_beat_t            obuf_wr;
    obuf_beat_t            head;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic                  sts_valid;
    logic [STS_W-1:0]      sts_data;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < C_AES_LATENCY; i++) begin
            inflight = inflight + 32'(tag_sr[i].valid);
        end
    end

    // Every beat in flight already owns a buffer slot, so a full buffer is never written.
    assign m_axis_mm2s_tready = (state == ST_RUN) && ((32'(occ) + inflight) < C_OBUF_DEPTH);
    assign accept             = m_axis_mm2s_tvalid && m_axis_mm2s_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            key_cap <= '0;
            aes_key <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_load) begin
                        key_cap <= key_in;
                        state   <= ST_DRAIN;
                    end else if (ctrl_en) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (key_load) begin
                        key_cap <= key_in;
                        state   <= ST_DRAIN;
                    end else if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (key_load) begin
                        key_cap <= key_in;
                    end else if (inflight == '0) begin
                        // Loaded on entry so the new key is already presented during LOAD.
                        aes_key <= key_cap;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (key_load) begin
                        key_cap <= key_in;
                        state   <= ST_DRAIN;
                    end else begin
                        state <= ctrl_en ? ST_RUN : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aes_state <= '0;
            for (int unsigned i = 0; i < C_AES_LATENCY; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            aes_state <= accept ? m_axis_mm2s_tdata : '0;
            tag_sr[0] <= '{valid: accept,
                           keep:  accept ? m_axis_mm2s_tkeep : '0,
                           last:  accept && m_axis_mm2s_tlast};
            for (int unsigned i = 1; i < C_AES_LATENCY; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign obuf_wr = '{data: aes_out,
                       keep: tag_sr[C_AES_LATENCY-1].keep,
                       last: tag_sr[C_AES_LATENCY-1].last};

    aes_obuf_fifo #(
        .DEPTH (C_OBUF_DEPTH),
        .WIDTH ($bits(obuf_beat_t))
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tag_sr[C_AES_LATENCY-1].valid),
        .wr_data (obuf_wr),
        .rd_en   (obuf_rd),
        .rd_data (head),
        .count   (occ)
    );

    // A frame's last beat waits until the previous frame's status is taken.
    assign obuf_empty         = (occ == '0);
    assign s_axis_s2mm_tvalid = !obuf_empty && !(head.last && sts_valid);
    assign s_axis_s2mm_tdata  = obuf_empty ? '0 : head.data;
    assign s_axis_s2mm_tkeep  = obuf_empty ? '0 : head.keep;
    assign s_axis_s2mm_tlast  = !obuf_empty && head.last;
    assign obuf_rd            = s_axis_s2mm_tvalid && s_axis_s2mm_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            sts_valid <= 1'b0;
            sts_data  <= '0;
        end else begin
            if (sts_valid && s_axis_s2mm_sts_tready) begin
                sts_valid <= 1'b0;
            end
            if (obuf_rd) begin
                if (head.last) begin
                    byte_cnt  <= '0;
                    sts_valid <= 1'b1;
                    sts_data  <= make_status(byte_cnt + BYTE_CNT_W'(keep_bytes(head.keep)));
                end else begin
                    byte_cnt <= byte_cnt + BYTE_CNT_W'(keep_bytes(head.keep));
                end
            end
        end
    end

    assign s_axis_s2mm_sts_tdata  = sts_data;
    assign s_axis_s2mm_sts_tkeep  = sts_valid ? 4'hF : 4'h0;
    assign s_axis_s2mm_sts_tvalid = sts_valid;
    assign s_axis_s2mm_sts_tlast  = sts_valid;

    assign busy = (state != ST_IDLE) || (inflight != '0) || !obuf_empty;

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameters SHALL be: C_TDATA_WIDTH, default 128, stream and AES block width (fixed at 128); C_AES_LATENCY, default 14, aes_256 clk-to-out latency in cycles; C_OBUF_DEPTH, default 16, output buffer entries (SHALL be at least C_AES_LATENCY+2).
REQ-002 m_axi_mm2s_aclk  in  1  sole clock; all logic rising-edge.
REQ-003 axi_reset  in  1  synchronous, active-high reset.
REQ-004 ctrl_en  in  1  level; 1 = accept input beats.
REQ-005 key_load  in  1  one-cycle request to install key_in; key_in  in  256  new key.
REQ-006 m_axis_mm2s_tdata/tkeep/tvalid/tlast  in  128/16/1/1; m_axis_mm2s_tready  out  1.
REQ-007 aes_state  out  128  plaintext to aes_256; aes_key  out  256  key to aes_256; aes_out  in  128  ciphertext from aes_256.
REQ-008 s_axis_s2mm_tdata/tkeep/tvalid/tlast  out  128/16/1/1; s_axis_s2mm_tready  in  1.
REQ-009 s_axis_s2mm_sts_tdata/tkeep/tvalid/tlast  out  32/4/1/1; s_axis_s2mm_sts_tready  in  1.
REQ-010 busy  out  1  state is not IDLE, or in-flight or buffered beats exist.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DRAIN, LOAD; IDLE->RUN when ctrl_en=1; RUN->IDLE when ctrl_en=0; RUN or IDLE->DRAIN on key_load=1 (key_in captured that cycle); DRAIN->LOAD when in-flight count is 0; LOAD->RUN after exactly one cycle if ctrl_en=1, else LOAD->IDLE.
REQ-012 aes_key SHALL update from the captured key only in LOAD; key_load arriving in DRAIN or LOAD SHALL overwrite the captured key and keep or return the FSM in DRAIN.
REQ-013 m_axis_mm2s_tready SHALL be 1 only in RUN with credits>0, where credits = C_OBUF_DEPTH - (buffer occupancy + in-flight count).
REQ-014 On an accepted input beat, aes_state SHALL equal the accepted tdata in that cycle (registered 0 otherwise), and a tag {valid,keep,last} SHALL enter a C_AES_LATENCY-deep shift register.
REQ-015 When a valid tag exits the shift register, aes_out with its keep/last SHALL be written to the output buffer in that cycle; no write SHALL ever target a full buffer, guaranteed by REQ-013.
REQ-016 The output buffer SHALL be FIFO-ordered with wrap-around pointers; simultaneous write and read SHALL leave occupancy unchanged.
REQ-017 s_axis_s2mm_tvalid SHALL equal buffer-not-empty, except it SHALL be 0 when the head beat has tlast=1 and s_axis_s2mm_sts_tvalid=1.
REQ-018 A 23-bit byte counter SHALL add popcount(tkeep) on each s2mm handshake, wrapping mod 2^23; on a handshake with tlast=1 it SHALL clear and load the status word.
REQ-019 The status word SHALL be: bit31=1, bits30:23=0, bits22:0=frame byte count including the last beat; sts_tkeep=4'hF; sts_tlast=1; sts_tvalid held until sts_tready.
REQ-020 ctrl_en deasserting mid-frame SHALL only stop acceptance; in-flight and buffered beats SHALL still drain to s2mm.

Reset
REQ-021 When axi_reset=1 at a clock edge: FSM=IDLE, tags, occupancy, pointers, counter cleared; aes_key=0; aes_state=0; all tvalid and tready outputs 0; all tdata, tkeep, tlast outputs 0; busy=0.
REQ-022 Reset mid-operation SHALL discard all in-flight and buffered beats and any pending status, with no partial output.

Structure
REQ-023 The FSM state encoding, status-word field positions and the 23-bit count width SHALL live in shared package aes_ctrl_pkg.
REQ-024 The output buffer SHALL be a separate sub-module aes_obuf_fifo (parameterised depth and width, count output); aes_256 SHALL be instantiated outside this block.

Verification
REQ-025 Single beat: key 256'h02 loaded, tkeep=16'hFFFF, tlast=1 -> s2mm beat appears C_AES_LATENCY+1 cycles after acceptance, then status 32'h8000_0010.
REQ-026 Backpressure: s2mm_tready=0 and 40 beats offered -> exactly 16 beats accepted, mm2s_tready=0 afterwards; release -> 40 beats out in order with no loss.
REQ-027 Key change mid-stream: key_load during a 5-beat frame -> no acceptance until in-flight=0, aes_key changes in the LOAD cycle, earlier beats use the old key.
REQ-028 Status stall: sts_tready=0 across two 3-beat frames, tkeep=16'h00FF on each last beat -> the second frame's last beat is held; statuses 32'h8000_0028 then 32'h8000_0028.
REQ-029 Reset mid-frame after 7 beats -> all valid outputs 0 next cycle, busy=0, and the next frame's status counts only its own bytes.
